// File: rtl/burst_line_port.sv
// Line port in front of BurstRAM: turns one cache-line read/write into one burst command.
// Optional read watchdog and sticky `timeout` output when BURST_LINE_PORT_TIMEOUT_EN is defined.
module burst_line_port #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              req,
    input  logic                                              req_we,
    input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]     req_line_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]              req_wr_line,
    input  logic [DATA_BITWIDTH*BURST_COUNT/8-1:0]            req_byte_en,
    output logic                                              req_ready,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]              rsp_line,
    output logic                                              rsp_valid,
    output logic                                              wr_done,
    output logic                                              mem_cmd,
    output logic                                              mem_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]                         mem_addr,
    output logic [DATA_BITWIDTH-1:0]                          mem_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                        mem_data_mask,
    input  logic [DATA_BITWIDTH-1:0]                          mem_rd_data,
    input  logic                                              mem_rd_data_valid,
    input  logic                                              mem_busy
`ifdef BURST_LINE_PORT_TIMEOUT_EN
    ,
    output logic                                              timeout
`endif
);

    localparam int LW = DATA_BITWIDTH * BURST_COUNT;
    localparam int BB = $clog2(BURST_COUNT);
    localparam int MW = DATA_BITWIDTH / 8;
    localparam int CW = (BB > 0) ? BB : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_COLLECT,
        RESP,
        WR_BURST
    } state_t;

    state_t          state;
    logic [CW-1:0]   beat;
    logic [CW-1:0]   beat_next;
    logic [LW-1:0]   wr_line_q;
    logic [LW/8-1:0] byte_en_q;
    logic [LW-1:0]   line_buf;
    logic [LW-1:0]   assembled;

`ifdef BURST_LINE_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign req_ready = (state == IDLE) && !mem_busy;
    assign beat_next = beat + 1'b1;

    // Gather buffer with the incoming beat merged in, so rsp_line only changes on a complete line.
    always_comb begin
        assembled = line_buf;
        assembled[beat*DATA_BITWIDTH +: DATA_BITWIDTH] = mem_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            wr_line_q     <= '0;
            byte_en_q     <= '0;
            line_buf      <= '0;
            rsp_line      <= '0;
            rsp_valid     <= 1'b0;
            wr_done       <= 1'b0;
            mem_cmd       <= 1'b0;
            mem_cmd_en    <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            mem_data_mask <= '0;
`ifdef BURST_LINE_PORT_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            rsp_valid  <= 1'b0;
            wr_done    <= 1'b0;
            mem_cmd    <= 1'b0;
            mem_cmd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !mem_busy) begin
                        mem_addr   <= {req_line_addr, {BB{1'b0}}};
                        wr_line_q  <= req_wr_line;
                        byte_en_q  <= req_byte_en;
                        beat       <= '0;
                        mem_cmd_en <= 1'b1;
                        if (req_we) begin
                            state         <= WR_BURST;
                            mem_cmd       <= 1'b1;
                            mem_wr_data   <= req_wr_line[DATA_BITWIDTH-1:0];
                            mem_data_mask <= ~req_byte_en[MW-1:0];
                            wr_done       <= (BURST_COUNT == 1);
                        end else begin
                            state <= RD_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    state <= RD_COLLECT;
                    beat  <= '0;
`ifdef BURST_LINE_PORT_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                RD_COLLECT: begin
                    if (mem_rd_data_valid) begin
                        line_buf <= assembled;
                        if (beat == LAST_BEAT) begin
                            rsp_line  <= assembled;
                            rsp_valid <= 1'b1;
                            beat      <= '0;
                            state     <= RESP;
                        end else begin
                            beat <= beat_next;
                        end
                    end
`ifdef BURST_LINE_PORT_TIMEOUT_EN
                    // Watchdog restarts on every beat; expiry abandons the line without a response.
                    if (mem_rd_data_valid) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_cnt <= '0;
                        timeout <= 1'b1;
                        beat    <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                WR_BURST: begin
                    if (beat == LAST_BEAT) begin
                        beat          <= '0;
                        mem_wr_data   <= '0;
                        mem_data_mask <= '0;
                        state         <= IDLE;
                    end else begin
                        beat          <= beat_next;
                        mem_wr_data   <= wr_line_q[beat_next*DATA_BITWIDTH +: DATA_BITWIDTH];
                        mem_data_mask <= ~byte_en_q[beat_next*MW +: MW];
                        wr_done       <= (beat_next == LAST_BEAT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_line_port.sv
// Directed testbench for burst_line_port; the bench plays the BurstRAM side from its own word array.
module tb_burst_line_port;

    localparam int DW  = 64;
    localparam int BC  = 4;
    localparam int LW  = DW * BC;
    localparam int TMO = 64;

    localparam logic [LW-1:0] L0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4,
                                    64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
    localparam logic [LW-1:0] L1 = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7,
                                    64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};
    localparam logic [LW-1:0] L1W = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7,
                                     64'hE1A7D0B5C8F3E6A9, 64'h1122334455667788};

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          req_we;
    logic [1:0]    req_line_addr;
    logic [LW-1:0] req_wr_line;
    logic [31:0]   req_byte_en;
    logic          req_ready;
    logic [LW-1:0] rsp_line;
    logic          rsp_valid;
    logic          wr_done;
    logic          mem_cmd;
    logic          mem_cmd_en;
    logic [3:0]    mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [7:0]    mem_data_mask;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_data_valid;
    logic          mem_busy;
`ifdef BURST_LINE_PORT_TIMEOUT_EN
    logic          timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [16];

    // Observation accumulators filled by observe() during a read
    int            obs_v;
    int            obs_c;
    logic [LW-1:0] obs_line;
    logic [3:0]    obs_addr;

    burst_line_port #(
        .DEPTH_BITWIDTH(4),
        .DATA_BITWIDTH (DW),
        .BURST_COUNT   (BC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_we           (req_we),
        .req_line_addr    (req_line_addr),
        .req_wr_line      (req_wr_line),
        .req_byte_en      (req_byte_en),
        .req_ready        (req_ready),
        .rsp_line         (rsp_line),
        .rsp_valid        (rsp_valid),
        .wr_done          (wr_done),
        .mem_cmd          (mem_cmd),
        .mem_cmd_en       (mem_cmd_en),
        .mem_addr         (mem_addr),
        .mem_wr_data      (mem_wr_data),
        .mem_data_mask    (mem_data_mask),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_data_valid(mem_rd_data_valid),
        .mem_busy         (mem_busy)
`ifdef BURST_LINE_PORT_TIMEOUT_EN
        ,
        .timeout          (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic init_ram();
        for (int i = 0; i < 16; i++) ram[i] = 64'h0;
        for (int b = 0; b < 4; b++) begin
            ram[b]     = L0[b*DW +: DW];
            ram[4 + b] = L1[b*DW +: DW];
        end
    endtask

    task automatic observe();
        if (mem_cmd_en && !mem_cmd) begin
            obs_c++;
            obs_addr = mem_addr;
        end
        if (rsp_valid) begin
            obs_v++;
            obs_line = rsp_line;
        end
    endtask

    // Issues one line read and serves it from ram; junk valid during RD_CMD must be ignored.
    task automatic run_read(input logic [1:0] la, input int gap_beat);
        logic [3:0] wa;
        obs_v = 0; obs_c = 0; obs_line = '0; obs_addr = 4'hF;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_line_addr = la;
        req_wr_line = {4{64'hBAD0BAD0BAD0BAD0}}; req_byte_en = '1;
        @(negedge clk);
        observe();
        req = 1'b0; req_we = 1'b1; req_line_addr = ~la;
        mem_rd_data_valid = 1'b1; mem_rd_data = 64'hDEADDEADDEADDEAD;
        for (int b = 0; b < BC; b++) begin
            @(negedge clk);
            observe();
            if (b == gap_beat) begin
                mem_rd_data_valid = 1'b0;
                @(negedge clk);
                observe();
            end
            wa = {la, 2'(b)};
            mem_rd_data_valid = 1'b1;
            mem_rd_data = ram[wa];
        end
        repeat (4) begin
            @(negedge clk);
            observe();
            mem_rd_data_valid = 1'b0;
            mem_rd_data = '0;
        end
    endtask

    task automatic test_reset();
        int bad_ready;
        rst = 1'b1; mem_busy = 1'b1; req = 1'b0; req_we = 1'b0; req_line_addr = '0;
        req_wr_line = '0; req_byte_en = '0; mem_rd_data = '0; mem_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, wr_done, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b/%b/%b/%b/%b addr=%h wd=%h mask=%h, required all 0",
                     req_ready, rsp_valid, wr_done, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask);
        end
        n_checks++;
        if (rsp_line !== '0) begin
            n_fail++; $display("[TB] FAIL reset_rsp_line: got %h, required 0", rsp_line);
        end
`ifdef BURST_LINE_PORT_TIMEOUT_EN
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_timeout: got %b, required 0", timeout);
        end
`endif
        rst = 1'b0;
        bad_ready = 0;
        mem_rd_data_valid = 1'b1; mem_rd_data = 64'h0123456789ABCDEF;
        repeat (10) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_ready !== 0) begin
            n_fail++; $display("[TB] FAIL busy_hold: %0d cycles with ready/rsp_valid set, required 0", bad_ready);
        end
        mem_busy = 1'b0; mem_rd_data_valid = 1'b0; mem_rd_data = '0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ready_after_busy: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_read_line0();
        run_read(2'd0, -1);
        n_checks++;
        if (obs_addr !== 4'd0) begin
            n_fail++; $display("[TB] FAIL rd0_addr: got %h, required 0", obs_addr);
        end
        n_checks++;
        if (obs_c !== 1) begin
            n_fail++; $display("[TB] FAIL rd0_cmd_pulses: got %0d, required 1", obs_c);
        end
        n_checks++;
        if (obs_v !== 1) begin
            n_fail++; $display("[TB] FAIL rd0_rsp_pulses: got %0d, required 1", obs_v);
        end
        n_checks++;
        if (obs_line !== L0) begin
            n_fail++; $display("[TB] FAIL rd0_line: got %h, required %h", obs_line, L0);
        end
        n_checks++;
        if (rsp_line !== L0 || req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rd0_hold: line %h ready %b, required %h / 1", rsp_line, req_ready, L0);
        end
    endtask

    task automatic test_read_line1_gap();
        run_read(2'd1, 2);
        n_checks++;
        if (obs_addr !== 4'd4) begin
            n_fail++; $display("[TB] FAIL rd1_addr: got %h, required 4", obs_addr);
        end
        n_checks++;
        if (obs_c !== 1 || obs_v !== 1) begin
            n_fail++; $display("[TB] FAIL rd1_pulses: cmd %0d rsp %0d, required 1 and 1", obs_c, obs_v);
        end
        n_checks++;
        if (obs_line !== L1) begin
            n_fail++; $display("[TB] FAIL rd1_line: got %h, required %h", obs_line, L1);
        end
    endtask

    task automatic test_busy_gating();
        int bad;
        bad = 0;
        @(negedge clk);
        mem_busy = 1'b1; req = 1'b1; req_we = 1'b0; req_line_addr = 2'd2;
        repeat (3) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || mem_cmd_en !== 1'b0) bad++;
        end
        req = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bad !== 0 || mem_cmd_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL busy_gating: %0d bad cycles, cmd_en %b, required 0 / 0", bad, mem_cmd_en);
        end
    endtask

    task automatic test_masked_write();
        logic [3:0]    en_seen, cmd_seen, done_seen;
        logic [7:0]    masks [4];
        logic [DW-1:0] wdata [4];
        logic [3:0]    waddr;
        logic [LW-1:0] wline;
        wline = {64'hFFEEDDCCBBAA9988, 64'hCAFEF00DCAFEF00D, 64'h0BAD0BAD0BAD0BAD, 64'h1122334455667788};
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_line_addr = 2'd1;
        req_wr_line = wline; req_byte_en = 32'h0000_00FF;
        for (int i = 0; i < BC; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req = 1'b0; req_wr_line = '1; req_byte_en = '1; waddr = mem_addr;
            end
            en_seen[i] = mem_cmd_en; cmd_seen[i] = mem_cmd; done_seen[i] = wr_done;
            masks[i] = mem_data_mask; wdata[i] = mem_wr_data;
            for (int j = 0; j < 8; j++)
                if (!mem_data_mask[j]) ram[waddr + 4'(i)][j*8 +: 8] = mem_wr_data[j*8 +: 8];
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wr_ready_last_beat: got %b, required 0", req_ready);
        end
        n_checks++;
        if (waddr !== 4'd4) begin
            n_fail++; $display("[TB] FAIL wr_addr: got %h, required 4", waddr);
        end
        n_checks++;
        if (en_seen !== 4'b0001 || cmd_seen[0] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL wr_cmd: cmd_en %b cmd0 %b, required 0001 / 1", en_seen, cmd_seen[0]);
        end
        n_checks++;
        if (done_seen !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL wr_done_pos: got %b, required 1000", done_seen);
        end
        n_checks++;
        if ({masks[3], masks[2], masks[1], masks[0]} !== 32'hFFFF_FF00) begin
            n_fail++; $display("[TB] FAIL wr_masks: got %h %h %h %h, required ff ff ff 00",
                               masks[3], masks[2], masks[1], masks[0]);
        end
        n_checks++;
        if ({wdata[3], wdata[2], wdata[1], wdata[0]} !== wline) begin
            n_fail++; $display("[TB] FAIL wr_beats: got %h %h %h %h, required %h",
                               wdata[3], wdata[2], wdata[1], wdata[0], wline);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || wr_done !== 1'b0 || mem_wr_data !== '0 || mem_data_mask !== '0) begin
            n_fail++; $display("[TB] FAIL wr_after: ready %b done %b wd %h mask %h, required 1 0 0 0",
                               req_ready, wr_done, mem_wr_data, mem_data_mask);
        end
        run_read(2'd1, -1);
        n_checks++;
        if (obs_v !== 1 || obs_line !== L1W) begin
            n_fail++; $display("[TB] FAIL wr_reread: pulses %0d line %h, required 1 / %h", obs_v, obs_line, L1W);
        end
    endtask

    task automatic test_mid_burst_reset();
        int extra_v, extra_c;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_line_addr = 2'd1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        mem_rd_data_valid = 1'b1; mem_rd_data = ram[4];
        @(negedge clk);
        mem_rd_data = ram[5];
        @(negedge clk);
        mem_rd_data_valid = 1'b0; mem_rd_data = '0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_line !== '0 || mem_cmd_en !== 1'b0 || mem_addr !== '0) begin
            n_fail++; $display("[TB] FAIL midrst_outputs: rsp_valid %b line %h cmd_en %b addr %h, required all 0",
                               rsp_valid, rsp_line, mem_cmd_en, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        extra_v = 0; extra_c = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) extra_v++;
            if (mem_cmd_en) extra_c++;
        end
        n_checks++;
        if (extra_v !== 0 || extra_c !== 0 || req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midrst_quiet: rsp %0d cmd %0d ready %b, required 0 0 1",
                               extra_v, extra_c, req_ready);
        end
        run_read(2'd0, 0);
        n_checks++;
        if (obs_v !== 1 || obs_line !== L0) begin
            n_fail++; $display("[TB] FAIL midrst_reread: pulses %0d line %h, required 1 / %h", obs_v, obs_line, L0);
        end
    endtask

`ifdef BURST_LINE_PORT_TIMEOUT_EN
    task automatic test_timeout();
        int k, pulses;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_line_addr = 2'd0;
        @(negedge clk);
        req = 1'b0;
        k = 0; pulses = 0;
        while (k < 200) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (timeout) break;
            k++;
        end
        n_checks++;
        if (k !== TMO) begin
            n_fail++; $display("[TB] FAIL timeout_cycles: got %0d, required %0d", k, TMO);
        end
        n_checks++;
        if (pulses !== 0 || req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL timeout_exit: rsp pulses %0d ready %b, required 0 / 1", pulses, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b1) begin
            n_fail++; $display("[TB] FAIL timeout_sticky: got %b, required 1", timeout);
        end
    endtask
`endif

    initial begin
        init_ram();
        test_reset();
        test_read_line0();
        test_read_line1_gap();
        test_busy_gating();
        test_masked_write();
        test_mid_burst_reset();
`ifdef BURST_LINE_PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
